// File: rtl/vpu_fp_sqrt_iter_pkg.sv
// Shared types and FP helpers for the iterative square-root unit.
// Formats, canonical NaN and class/state encodings live here.
package vpu_fp_sqrt_iter_pkg;

  localparam int EXP_W_DEF = 8;
  localparam int MAN_W_DEF = 23;

  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_INF,
    CLS_QNAN,
    CLS_SNAN,
    CLS_NEG
  } fp_cls_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREP,
    ST_ITER,
    ST_ROUND
  } state_e;

  function automatic int bias(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction

  // BIAS is odd, so (E + BIAS - odd) / 2 == E[hi:1] + BIAS/2 + E[0]
  function automatic int half_bias(input int ew);
    return bias(ew) >> 1;
  endfunction

  function automatic logic [63:0] qnan_bits(input int ew, input int mw);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < ew; i++) r[mw+i] = 1'b1;
    r[mw-1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/vpu_fp_sqrt_iter_if.sv
// Source/destination bundle of the square-root unit.
// The master issues operands; the slave returns results.
interface vpu_fp_sqrt_iter_if #(
  parameter int LANES = 4,
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int ELEM_W = 1 + EXP_W + MAN_W;

  logic                    start_i;
  logic [LANES*ELEM_W-1:0] op_0;
  logic [LANES*ELEM_W-1:0] result_o;
  logic                    done_o;
  logic                    busy_o;
  logic [LANES-1:0]        invalid_o;

  modport master (
    output start_i, op_0,
    input  result_o, done_o, busy_o, invalid_o
  );

  modport slave (
    input  start_i, op_0,
    output result_o, done_o, busy_o, invalid_o
  );
endinterface

// File: rtl/vpu_fp_sqrt_iter_lane.sv
// One lane: unpack/classify, restoring root recurrence, RNE round.
// Sequenced by shared cap/prep/iter/round strobes from the top FSM.
module vpu_fp_sqrt_iter_lane
  import vpu_fp_sqrt_iter_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cap_i,
  input  logic                       prep_i,
  input  logic                       iter_i,
  input  logic                       round_i,
  input  logic [1+EXP_W+MAN_W-1:0]   op_i,
  output logic [1+EXP_W+MAN_W-1:0]   res_o,
  output logic                       inv_o
);
  localparam int ELEM_W = 1 + EXP_W + MAN_W;
  localparam int RT_W   = MAN_W + 2;
  localparam int RAD_W  = 2 * RT_W;
  localparam int REM_W  = MAN_W + 5;
  localparam int HB     = half_bias(EXP_W);
  localparam logic [EXP_W-1:0] HALF_B = HB[EXP_W-1:0];
  localparam logic [63:0] QNAN_L = qnan_bits(EXP_W, MAN_W);
  localparam logic [ELEM_W-1:0] QNAN = QNAN_L[ELEM_W-1:0];

  logic [ELEM_W-1:0] op_q;
  logic              sgn_q;
  fp_cls_e           cls_q;
  logic [EXP_W-1:0]  exp_q;
  logic [RAD_W-1:0]  rad_q;
  logic [RT_W-1:0]   root_q;
  logic [REM_W-1:0]  rem_q;
  logic [ELEM_W-1:0] res_q;
  logic              inv_q;

  logic              sgn;
  logic [EXP_W-1:0]  ef;
  logic [MAN_W-1:0]  mf;
  logic              nan;
  fp_cls_e           cls_d;
  logic [EXP_W-1:0]  exp_d;
  logic [RT_W-1:0]   rt0;
  logic [RAD_W-1:0]  rad_d;

  logic [REM_W-1:0]  rem_sh;
  logic [REM_W:0]    trial;
  logic              ge;
  logic [REM_W-1:0]  rem_d;
  logic [RT_W-1:0]   root_d;

  logic              up;
  logic [MAN_W:0]    man_r;
  logic [EXP_W-1:0]  exp_r;
  logic [ELEM_W-1:0] res_d;
  logic              inv_d;

  // Classify the captured operand and derive exponent and radicand
  always_comb begin
    sgn   = op_q[ELEM_W-1];
    ef    = op_q[MAN_W +: EXP_W];
    mf    = op_q[MAN_W-1:0];
    nan   = (&ef) & (|mf);
    cls_d = CLS_NORM;
    unique case (1'b1)
      nan & mf[MAN_W-1]:          cls_d = CLS_QNAN;
      nan & ~mf[MAN_W-1]:         cls_d = CLS_SNAN;
      ~|ef:                       cls_d = CLS_ZERO;
      sgn & ~nan & (|ef):         cls_d = CLS_NEG;
      (&ef) & ~(|mf) & ~sgn:      cls_d = CLS_INF;
      default:                    cls_d = CLS_NORM;
    endcase
    exp_d = {1'b0, ef[EXP_W-1:1]} + HALF_B
          + {{(EXP_W-1){1'b0}}, ef[0]};
    rt0   = ef[0] ? {2'b01, mf} : {1'b1, mf, 1'b0};
    rad_d = {rt0, {RT_W{1'b0}}};
  end

  // One restoring step: trial-subtract 4*root+1 from the shifted remainder
  always_comb begin
    rem_sh = {rem_q[REM_W-3:0], rad_q[RAD_W-1 -: 2]};
    trial  = {1'b0, rem_sh}
           - {1'b0, {(REM_W-RT_W-2){1'b0}}, root_q, 2'b01};
    ge     = ~trial[REM_W];
    rem_d  = ge ? trial[REM_W-1:0] : rem_sh;
    root_d = {root_q[RT_W-2:0], ge};
  end

  // Round to nearest even and pick the special-case encodings
  always_comb begin
    up    = root_q[0] & ((|rem_q) | root_q[1]);
    man_r = {1'b0, root_q[MAN_W:1]} + {{MAN_W{1'b0}}, up};
    exp_r = exp_q + {{(EXP_W-1){1'b0}}, man_r[MAN_W]};
    res_d = '0;
    inv_d = 1'b0;
    unique case (cls_q)
      CLS_ZERO: res_d = {sgn_q, {(ELEM_W-1){1'b0}}};
      CLS_NORM: res_d = {1'b0, exp_r,
                         man_r[MAN_W] ? {MAN_W{1'b0}}
                                      : man_r[MAN_W-1:0]};
      CLS_INF:  res_d = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      CLS_QNAN: res_d = QNAN;
      CLS_SNAN, CLS_NEG: begin
        res_d = QNAN;
        inv_d = 1'b1;
      end
      default:  res_d = '0;
    endcase
  end

  // Lane state: capture, prepare, iterate, then hold the rounded result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      sgn_q  <= 1'b0;
      cls_q  <= CLS_ZERO;
      exp_q  <= '0;
      rad_q  <= '0;
      root_q <= '0;
      rem_q  <= '0;
      res_q  <= '0;
      inv_q  <= 1'b0;
    end else begin
      if (cap_i) op_q <= op_i;
      if (prep_i) begin
        sgn_q  <= sgn;
        cls_q  <= cls_d;
        exp_q  <= exp_d;
        rad_q  <= rad_d;
        root_q <= '0;
        rem_q  <= '0;
      end
      if (iter_i) begin
        rad_q  <= {rad_q[RAD_W-3:0], 2'b00};
        rem_q  <= rem_d;
        root_q <= root_d;
      end
      if (round_i) begin
        res_q <= res_d;
        inv_q <= inv_d;
      end
    end
  end

  assign res_o = res_q;
  assign inv_o = inv_q;

endmodule

// File: rtl/vpu_fp_sqrt_iter.sv
// Multi-lane IEEE-754 square root with a shared sequencing FSM.
// Fixed latency of MAN_W+4 cycles from accept to the done pulse.
module vpu_fp_sqrt_iter
  import vpu_fp_sqrt_iter_pkg::*;
#(
  parameter int LANES = 4,
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  vpu_fp_sqrt_iter_if.slave    sq
);
  localparam int ELEM_W = 1 + EXP_W + MAN_W;
  localparam int CNT_W  = $clog2(MAN_W + 2);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAN_W + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              cap, prep, iter, rnd;

  logic [LANES*ELEM_W-1:0] res_w;
  logic [LANES-1:0]        inv_w;

  // State, counter and done pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Next state and per-phase lane strobes
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    cap     = 1'b0;
    prep    = 1'b0;
    iter    = 1'b0;
    rnd     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (sq.start_i) begin
          cap     = 1'b1;
          state_d = ST_PREP;
        end
      end
      ST_PREP: begin
        prep    = 1'b1;
        cnt_d   = '0;
        state_d = ST_ITER;
      end
      ST_ITER: begin
        iter  = 1'b1;
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_q == LAST) state_d = ST_ROUND;
      end
      ST_ROUND: begin
        rnd     = 1'b1;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    vpu_fp_sqrt_iter_lane #(
      .EXP_W (EXP_W),
      .MAN_W (MAN_W)
    ) u_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .cap_i   (cap),
      .prep_i  (prep),
      .iter_i  (iter),
      .round_i (rnd),
      .op_i    (sq.op_0[g*ELEM_W +: ELEM_W]),
      .res_o   (res_w[g*ELEM_W +: ELEM_W]),
      .inv_o   (inv_w[g])
    );
  end

  assign sq.result_o  = res_w;
  assign sq.invalid_o = inv_w;
  assign sq.done_o    = done_q;
  assign sq.busy_o    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_vpu_fp_sqrt_iter.sv
// Scoreboard bench: fp32 and fp16 instances, directed vectors.
// Stimulus pushes expectations; monitors pop on each done pulse.
module tb_vpu_fp_sqrt_iter;

  typedef struct {
    logic [127:0] res;
    logic [3:0]   inv;
    int           t;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t q32[$];
  exp_t q16[$];

  vpu_fp_sqrt_iter_if #(.LANES(4), .EXP_W(8), .MAN_W(23)) if32();
  vpu_fp_sqrt_iter_if #(.LANES(4), .EXP_W(5), .MAN_W(10)) if16();

  vpu_fp_sqrt_iter #(.LANES(4), .EXP_W(8), .MAN_W(23)) u_dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .sq    (if32)
  );

  vpu_fp_sqrt_iter #(.LANES(4), .EXP_W(5), .MAN_W(10)) u_dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .sq    (if16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] ex);
    n_tests++;
    if (act !== ex) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, ex);
    end
  endtask

  // fp32 monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && if32.done_o) begin
      if (q32.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL spurious_done32: got done_o=1, required no done");
      end else begin
        e = q32.pop_front();
        chk("res32", 128'(if32.result_o), e.res);
        chk("inv32", 128'(if32.invalid_o), 128'(e.inv));
        chk("lat32", 128'(cyc - e.t), 128'(27));
        chk("busy_in_done32", 128'(if32.busy_o), 128'(0));
      end
    end
  end

  // fp16 monitor
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && if16.done_o) begin
      if (q16.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL spurious_done16: got done_o=1, required no done");
      end else begin
        e = q16.pop_front();
        chk("res16", 128'(if16.result_o), e.res);
        chk("inv16", 128'(if16.invalid_o), 128'(e.inv));
        chk("lat16", 128'(cyc - e.t), 128'(14));
      end
    end
  end

  task automatic issue32(input logic [127:0] op, input logic [127:0] res,
                         input logic [3:0] inv, input bit push);
    exp_t e;
    if32.op_0    = op;
    if32.start_i = 1'b1;
    if (push) begin
      e.res = res;
      e.inv = inv;
      e.t   = cyc + 1;
      q32.push_back(e);
    end
    @(posedge clk);
    #1;
    if32.start_i = 1'b0;
  endtask

  task automatic issue16(input logic [63:0] op, input logic [63:0] res,
                         input logic [3:0] inv);
    exp_t e;
    if16.op_0    = op;
    if16.start_i = 1'b1;
    e.res = 128'(res);
    e.inv = inv;
    e.t   = cyc + 1;
    q16.push_back(e);
    @(posedge clk);
    #1;
    if16.start_i = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int i;
    i = 0;
    while ((q32.size() != 0 || q16.size() != 0) && i < budget) begin
      @(negedge clk);
      #1;
      i++;
    end
    n_tests++;
    if (q32.size() != 0 || q16.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d+%0d results pending, required 0",
               q32.size(), q16.size());
      q32.delete();
      q16.delete();
    end
  endtask

  localparam logic [127:0] OP2  = {32'h7F7FFFFF, 32'h3E800000,
                                   32'h40000000, 32'h40800000};
  localparam logic [127:0] RS2  = {32'h5F7FFFFF, 32'h3F000000,
                                   32'h3FB504F3, 32'h40000000};
  localparam logic [127:0] OP3  = {32'h7F800001, 32'h7F800000,
                                   32'h80000000, 32'hBF800000};
  localparam logic [127:0] RS3  = {32'h7FC00000, 32'h7F800000,
                                   32'h80000000, 32'h7FC00000};
  localparam logic [127:0] OP4  = {32'hFF800000, 32'h7FC12345,
                                   32'h80000001, 32'h00000001};
  localparam logic [127:0] RS4  = {32'h7FC00000, 32'h7FC00000,
                                   32'h80000000, 32'h00000000};
  localparam logic [63:0]  OP16 = {16'h3C00, 16'h3C01,
                                   16'h4000, 16'h4400};
  localparam logic [63:0]  RS16 = {16'h3C00, 16'h3C00,
                                   16'h3DA8, 16'h4000};

  initial begin
    bit seen;
    rst_n        = 1'b0;
    if32.start_i = 1'b0;
    if32.op_0    = '0;
    if16.start_i = 1'b0;
    if16.op_0    = '0;
    repeat (3) @(negedge clk);
    chk("rst_result", 128'(if32.result_o), 128'(0));
    chk("rst_done", 128'(if32.done_o), 128'(0));
    chk("rst_busy", 128'(if32.busy_o), 128'(0));
    chk("rst_invalid", 128'(if32.invalid_o), 128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // fp32 normal operands
    issue32(OP2, RS2, 4'b0000, 1'b1);
    wait_drain(60);

    // Handshake: ignored start while busy, accept in the done cycle
    @(negedge clk);
    issue32(OP3, RS3, 4'b1001, 1'b1);
    repeat (4) @(negedge clk);
    chk("busy_mid", 128'(if32.busy_o), 128'(1));
    if32.op_0    = OP4;
    if32.start_i = 1'b1;
    @(posedge clk);
    #1;
    if32.start_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (if32.done_o) seen = 1'b1;
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL done_wait: got no done_o, required one");
    end else begin
      issue32(OP4, RS4, 4'b1000, 1'b1);
      repeat (10) @(negedge clk);
      chk("hold_result", 128'(if32.result_o), RS3);
      chk("hold_invalid", 128'(if32.invalid_o), 128'(4'b1001));
    end
    wait_drain(60);

    // fp16 instance
    @(negedge clk);
    issue16(OP16, RS16, 4'b0000);
    wait_drain(40);

    // Reset mid-ITER aborts the operation
    @(negedge clk);
    issue32(OP3, RS3, 4'b0000, 1'b0);
    repeat (9) @(negedge clk);
    chk("busy_pre_rst", 128'(if32.busy_o), 128'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_result", 128'(if32.result_o), 128'(0));
    chk("abort_done", 128'(if32.done_o), 128'(0));
    chk("abort_busy", 128'(if32.busy_o), 128'(0));
    chk("abort_invalid", 128'(if32.invalid_o), 128'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    // Recovery after reset
    issue32(OP2, RS2, 4'b0000, 1'b1);
    wait_drain(60);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
